// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC and status-flag sequencer with start/run/done control
// Drives the instruction ROM address and returns the registered FLAG to the decoder.
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  Target,
  input  logic             flag_write,
  input  logic             flag_d,
  input  logic             overflow_write,
  input  logic             overflow_d,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             FLAG_OUT,
  output logic             OVERFLOW_OUT,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flag  <= w_flag_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flag_nxt  = r_flag;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        // Flag writes and the counter tick commit even on the Halt edge.
        if (flag_write)     w_flag_nxt = flag_d;
        if (overflow_write) w_ovf_nxt  = overflow_d;
        if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        if (Halt)           w_state_nxt = S_DONE;
        else if (branch_en) w_pc_nxt    = Target;
        else                w_pc_nxt    = r_pc + 1'b1;
      end
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = START_PC;
          w_flag_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ProgCtr      = r_pc;
  assign FLAG_OUT     = r_flag;
  assign OVERFLOW_OUT = r_ovf;
  assign Running      = (r_state == S_RUN);
  assign Done         = (r_state == S_DONE);
  assign CycleCount   = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench against a behavioural model
// A default-size instance and a narrow (PC_W=4, CNT_W=4, START_ADDR=14) instance share stimulus.
module tb_fetch_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int st;
    int pc;
    bit flag;
    bit ovf;
    int cnt;
  } model_t;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, branch_en, flag_write, flag_d, overflow_write, overflow_d;
  logic [9:0] Target;

  logic [9:0]  pc_b;
  logic        flag_b, ovf_b, run_b, done_b;
  logic [15:0] cnt_b;
  logic [3:0]  pc_s, cnt_s;
  logic        flag_s, ovf_s, run_s, done_s;

  int n_tests = 0;
  int n_fail  = 0;
  model_t mb, ms;

  always #5 Clk = ~Clk;

  fetch_sequencer u_big (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .branch_en(branch_en),
    .Target(Target), .flag_write(flag_write), .flag_d(flag_d),
    .overflow_write(overflow_write), .overflow_d(overflow_d),
    .ProgCtr(pc_b), .FLAG_OUT(flag_b), .OVERFLOW_OUT(ovf_b),
    .Running(run_b), .Done(done_b), .CycleCount(cnt_b)
  );

  fetch_sequencer #(.PC_W(4), .START_ADDR(14), .CNT_W(4)) u_small (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .branch_en(branch_en),
    .Target(Target[3:0]), .flag_write(flag_write), .flag_d(flag_d),
    .overflow_write(overflow_write), .overflow_d(overflow_d),
    .ProgCtr(pc_s), .FLAG_OUT(flag_s), .OVERFLOW_OUT(ovf_s),
    .Running(run_s), .Done(done_s), .CycleCount(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t step(input model_t m, input int pw, input int cw, input int sa);
    model_t n;
    n = m;
    if (Reset) begin
      n.st = M_IDLE; n.pc = 0; n.flag = 0; n.ovf = 0; n.cnt = 0;
    end else if (m.st == M_RUN) begin
      if (flag_write)     n.flag = flag_d;
      if (overflow_write) n.ovf  = overflow_d;
      n.cnt = (m.cnt + 1 > (1 << cw) - 1) ? (1 << cw) - 1 : m.cnt + 1;
      if (Halt)           n.st = M_DONE;
      else if (branch_en) n.pc = int'(Target) % (1 << pw);
      else                n.pc = (m.pc + 1) % (1 << pw);
    end else if (Start) begin
      n.st = M_RUN; n.pc = sa; n.flag = 0; n.ovf = 0; n.cnt = 0;
    end
    return n;
  endfunction

  task automatic compare_all();
    check("b_pc",   32'(pc_b),   32'(mb.pc));
    check("b_flag", 32'(flag_b), 32'(mb.flag));
    check("b_ovf",  32'(ovf_b),  32'(mb.ovf));
    check("b_run",  32'(run_b),  32'(mb.st == M_RUN));
    check("b_done", 32'(done_b), 32'(mb.st == M_DONE));
    check("b_cnt",  32'(cnt_b),  32'(mb.cnt));
    check("s_pc",   32'(pc_s),   32'(ms.pc));
    check("s_flag", 32'(flag_s), 32'(ms.flag));
    check("s_ovf",  32'(ovf_s),  32'(ms.ovf));
    check("s_run",  32'(run_s),  32'(ms.st == M_RUN));
    check("s_done", 32'(done_s), 32'(ms.st == M_DONE));
    check("s_cnt",  32'(cnt_s),  32'(ms.cnt));
  endtask

  task automatic tick();
    @(posedge Clk);
    mb = step(mb, 10, 16, 0);
    ms = step(ms, 4, 4, 14);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic clear_in();
    Reset = 0; Start = 0; Halt = 0; branch_en = 0; Target = '0;
    flag_write = 0; flag_d = 0; overflow_write = 0; overflow_d = 0;
  endtask

  initial begin
    mb = '{M_IDLE, 0, 1'b0, 1'b0, 0};
    ms = mb;
    clear_in();
    Reset = 1;
    @(negedge Clk);
    tick();
    check("rst_pc", 32'(pc_b), 0);
    check("rst_flag", 32'(flag_b), 0);
    check("rst_cnt", 32'(cnt_b), 0);
    check("rst_done", 32'(done_b | run_b), 0);
    Reset = 0;
    tick();

    // Straight-line run with Halt at PC 5
    Start = 1; tick(); Start = 0;
    for (int i = 0; i < 6; i++) begin
      check("seq_pc", 32'(pc_b), 32'(i));
      if (i < 4) begin
        check("small_pc", 32'(pc_s), 32'((14 + i) % 16));
        check("small_nodone", 32'(done_s), 0);
      end
      Halt = (i == 5);
      tick();
    end
    Halt = 0;
    check("halt_done", 32'(done_b), 1);
    check("halt_pc", 32'(pc_b), 5);
    check("halt_cnt", 32'(cnt_b), 6);

    // Compare then branch, no bypass needed
    Start = 1; tick(); Start = 0;
    repeat (3) tick();
    flag_write = 1; flag_d = 1; tick(); flag_write = 0;
    check("flag_vis", 32'(flag_b), 1);
    branch_en = 1; Target = 10'd40; tick(); branch_en = 0;
    check("branch_pc", 32'(pc_b), 40);

    // Halt beats branch; overflow write in the Halt cycle commits
    branch_en = 1; Target = 10'd7; tick();
    Halt = 1; Target = 10'd100; overflow_write = 1; overflow_d = 1; tick();
    clear_in();
    check("hb_done", 32'(done_b), 1);
    check("hb_pc", 32'(pc_b), 7);
    check("hb_ovf", 32'(ovf_b), 1);

    // Writes ignored in DONE, then relaunch clears state
    flag_write = 1; flag_d = 0; Halt = 1; tick(); clear_in();
    check("done_flag_hold", 32'(flag_b), 1);
    Start = 1; tick(); Start = 0;
    check("relaunch_pc", 32'(pc_b), 0);
    check("relaunch_flag", 32'(flag_b), 0);
    check("relaunch_ovf", 32'(ovf_b), 0);
    check("relaunch_cnt", 32'(cnt_b), 0);
    tick(); tick();
    Start = 1; tick(); Start = 0;
    check("start_in_run", 32'(pc_b), 3);

    // Reset mid-run drops the in-flight flag write
    branch_en = 1; Target = 10'd9; tick(); branch_en = 0;
    Reset = 1; flag_write = 1; flag_d = 1; tick(); clear_in();
    check("midrst_pc", 32'(pc_b), 0);
    check("midrst_flag", 32'(flag_b), 0);
    check("midrst_run", 32'(run_b), 0);

    // Counter saturation on the narrow instance
    Start = 1; tick(); Start = 0;
    repeat (20) tick();
    check("sat_small", 32'(cnt_s), 15);
    check("sat_big", 32'(cnt_b), 20);

    for (int i = 0; i < 3000; i++) begin
      Reset          = ($urandom % 100) == 0;
      Start          = ($urandom % 8) == 0;
      Halt           = ($urandom % 16) == 0;
      branch_en      = ($urandom % 4) == 0;
      Target         = 10'($urandom);
      flag_write     = 1'($urandom);
      flag_d         = 1'($urandom);
      overflow_write = 1'($urandom);
      overflow_d     = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter and status-flag sequencer on the consuming end of the control decoder. It holds the architectural FLAG and OVERFLOW bits and returns FLAG_OUT to the decoder. It applies the decoder's branch_en, flag_write and overflow_write strobes to advance or redirect the PC each cycle. It also runs a start/run/done state machine and a saturating cycle counter for the testbench.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
START_ADDR, 0, PC value loaded on Start.
CNT_W, 16, cycle counter width.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  launch or relaunch a program; sampled in IDLE or DONE only.
Halt  input  1  current instruction is the halt instruction.
branch_en  input  1  take branch this cycle, from the decoder.
Target  input  PC_W  absolute branch destination from the branch LUT.
flag_write  input  1  load FLAG from flag_d (compare instructions).
flag_d  input  1  compare result from the ALU.
overflow_write  input  1  load OVERFLOW from overflow_d.
overflow_d  input  1  carry/overflow result from the ALU.
ProgCtr  output  PC_W  instruction ROM address.
FLAG_OUT  output  1  registered FLAG, fed back to the decoder's FLAG_IN.
OVERFLOW_OUT  output  1  registered OVERFLOW bit.
Running  output  1  high while in RUN.
Done  output  1  high while in DONE.
CycleCount  output  CNT_W  number of RUN cycles since the last Start.

Behaviour:
- States: IDLE, RUN, DONE; encoded as a 2-bit register.
- Reset (synchronous, highest priority) sets:
  - state to IDLE;
  - ProgCtr, FLAG_OUT, OVERFLOW_OUT and CycleCount to 0;
  - Running and Done to 0.
- Reset asserted mid-RUN aborts the program on that edge. No flag or PC update from that cycle commits.
- Running and Done are decoded from the state register with no extra delay.
- IDLE:
  - PC, flags and counter hold.
  - Start=1 -> RUN next edge; ProgCtr<=START_ADDR; FLAG and OVERFLOW <=0; CycleCount<=0.
- RUN, evaluated every edge in this priority order:
  - Halt=1 -> DONE; ProgCtr holds, pointing at the halt instruction.
  - else branch_en=1 -> ProgCtr<=Target.
  - else ProgCtr<=ProgCtr+1, modulo 2^PC_W; 2^PC_W-1 wraps to 0.
- Halt beats branch_en when both are high in the same cycle.
- In RUN, flag_write=1 -> FLAG<=flag_d and overflow_write=1 -> OVERFLOW<=overflow_d.
  - The two writes are independent and may occur in the same cycle.
  - Flag writes in the Halt cycle still commit.
  - Write enables are ignored outside RUN.
- A flag written in cycle N is visible on FLAG_OUT from cycle N+1. A compare followed immediately by a branch sees the new value; no bypass.
- CycleCount increments on every RUN edge, including the Halt edge. It saturates at 2^CNT_W-1 with no wrap.
- DONE:
  - Done=1; ProgCtr, flags and CycleCount hold.
  - Start=1 relaunches exactly as from IDLE.
  - Halt, branch_en and the write enables are ignored.
- Start while in RUN is ignored.
- Latency: one cycle from Start to the first fetch at START_ADDR. ProgCtr is registered, so a branch decision in cycle N addresses Target in cycle N+1.

Test Plan:
- Reset, then Start pulse, no branches, Halt at ProgCtr=5 -> ProgCtr sequence 0,1,2,3,4,5; Done=1 with ProgCtr=5; CycleCount=6.
- In RUN at ProgCtr=3: flag_write=1 with flag_d=1, next cycle branch_en=1 with Target=40 -> FLAG_OUT=1 from cycle 4; ProgCtr=40 on the cycle after the branch.
- Halt=1 and branch_en=1 together at ProgCtr=7 with overflow_write=1, overflow_d=1 -> DONE; ProgCtr stays 7; OVERFLOW_OUT=1.
- PC_W=4: run with no branch from ProgCtr=14 -> 14,15,0,1; no Done. Force CNT_W=4 and run 20 cycles -> CycleCount saturates at 15.
- Reset asserted mid-RUN at ProgCtr=9 with flag_write=1, flag_d=1 -> next edge: IDLE, ProgCtr=0, FLAG_OUT=0, CycleCount=0.
- In DONE, set FLAG_OUT=1, then pulse Start -> RUN; ProgCtr=START_ADDR; FLAG_OUT=0; OVERFLOW_OUT=0; CycleCount restarts from 0. Start pulsed during RUN -> no effect on ProgCtr.
